// File: rtl/scnn_accum_scatter.sv
// Scatter-accumulate stage: drains a batch of products into a saturating accumulator
// bank one live lane per cycle, and streams the bank out (clearing it) on request.
//
// state   | meaning
// IDLE    | waiting for a batch or a drain request
// ACCUM   | adding the registered batch, lowest live lane first
// DRAIN   | streaming acc[pointer] out and clearing each entry on handshake
module scnn_accum_scatter #(
    parameter int NUM_PROD = 16,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 24,
    parameter int DEPTH    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_PROD*DATA_W-1:0] in_prod,
    input  logic [NUM_PROD*8-1:0]      in_cords,
    input  logic                       drain_start,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_addr,
    output logic [ACC_W-1:0]           out_data,
    output logic                       busy,
    output logic                       sat_flag
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam logic [8:0] DEPTH_C  = 9'(DEPTH);
    localparam logic [7:0] LAST_PTR = 8'(DEPTH - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    state_t                     state;
    logic [NUM_PROD*DATA_W-1:0] prod_q;
    logic [NUM_PROD*AW-1:0]     cords_q;
    logic [NUM_PROD-1:0]        live_mask;
    logic [7:0]                 pointer;
    logic                       sat_q;
    logic [ACC_W-1:0]           acc [DEPTH];

    logic [NUM_PROD-1:0] live_in;
    logic [NUM_PROD-1:0] next_mask;
    logic [SW-1:0]       sel;
    logic [DATA_W-1:0]   sel_prod;
    logic [AW-1:0]       sel_idx;
    logic [ACC_W-1:0]    cur_acc;
    logic [ACC_W:0]      prod_ext;
    logic [ACC_W:0]      sum;
    logic                ovf;
    logic [ACC_W-1:0]    new_val;

    always_comb begin
        for (int k = 0; k < NUM_PROD; k++) begin
            live_in[k] = ({1'b0, in_cords[k*8 +: 8]} < DEPTH_C) &&
                         (in_prod[k*DATA_W +: DATA_W] != '0);
        end
    end

    always_comb begin
        sel = '0;
        for (int k = NUM_PROD - 1; k >= 0; k--) begin
            if (live_mask[k]) sel = SW'(k);
        end
    end

    // Clearing the lowest set bit matches the lane chosen by the priority encoder above.
    assign next_mask = live_mask & (live_mask - 1'b1);
    assign sel_prod  = prod_q[sel*DATA_W +: DATA_W];
    assign sel_idx   = cords_q[sel*AW +: AW];
    assign cur_acc   = acc[sel_idx];
    assign prod_ext  = {{(ACC_W + 1 - DATA_W){sel_prod[DATA_W-1]}}, sel_prod};
    assign sum       = {cur_acc[ACC_W-1], cur_acc} + prod_ext;
    assign ovf       = sum[ACC_W] ^ sum[ACC_W-1];
    assign new_val   = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prod_q    <= '0;
            cords_q   <= '0;
            live_mask <= '0;
            pointer   <= '0;
            sat_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (drain_start) begin
                        state   <= S_DRAIN;
                        pointer <= '0;
                        sat_q   <= 1'b0;
                    end else if (in_valid) begin
                        prod_q    <= in_prod;
                        live_mask <= live_in;
                        for (int k = 0; k < NUM_PROD; k++) begin
                            cords_q[k*AW +: AW] <= in_cords[k*8 +: AW];
                        end
                        if (|live_in) state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc[sel_idx] <= new_val;
                    if (ovf) sat_q <= 1'b1;
                    live_mask <= next_mask;
                    if (next_mask == '0) state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        acc[pointer[AW-1:0]] <= '0;
                        if (pointer == LAST_PTR) begin
                            state   <= S_IDLE;
                            pointer <= '0;
                        end else begin
                            pointer <= pointer + 8'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE) && !drain_start;
    assign out_valid = (state == S_DRAIN);
    assign out_addr  = out_valid ? pointer : 8'd0;
    assign out_data  = out_valid ? acc[pointer[AW-1:0]] : '0;
    assign busy      = (state != S_IDLE);
    assign sat_flag  = sat_q;

endmodule
